rom_dma_scheduler: RTL and testbench
====================================

// Module: rom_dma_scheduler
// PURPOSE
//  Shares the single ROM DMA engine between NUM_REQ requesters.
//  - Each requester posts one read job: base address plus word count.
//  - Jobs are granted round-robin and split into chunks of at most MAX_CHUNK words,
//    so one long job cannot starve the other requesters.
//  - For each chunk the block programs the engine's cfg/start interface, waits for
//    batch done, then clears the engine. It signals per-requester completion.
// PARAMETERS
//  NUM_REQ         4   number of requester slots (>=2)
//  ROM_ADDR_WIDTH  16  address/count width; equals the shared package constant
//  MAX_CHUNK       64  maximum words per engine batch (1..2**ROM_ADDR_WIDTH-1)
// PORTS
//  clk               in   1               clock
//  reset_n           in   1               synchronous, active-low reset
//  req_valid         in   NUM_REQ         job offer, one bit per requester
//  req_ready         out  NUM_REQ         slot empty; job accepted when valid&ready
//  req_base_addr     in   NUM_REQ*AW      packed job base addresses (slot i = [i*AW+:AW])
//  req_num_words     in   NUM_REQ*AW      packed job word counts
//  req_done          out  NUM_REQ         1-cycle pulse when slot's whole job is finished
//  dma_cfg_base_addr out  AW              engine base address
//  dma_cfg_num_bytes out  AW              engine batch length (current chunk)
//  dma_start_rd      out  1               engine start
//  dma_cfg_ready     out  1               engine config valid
//  dma_batch_done    in   1               engine: batch counter == length
//  sched_busy        out  1               a chunk is in LOAD/RUN/RETIRE
//  grant_id          out  $clog2(NUM_REQ) slot currently owning the engine
// BEHAVIOUR
//  Reset values
//  - All outputs are 0, except req_ready, which is all 1s.
//  - All slots are empty and the round-robin pointer is 0.
//  - Reset mid-chunk abandons the job. The engine sees start=0, cfg=0 and clears itself.
//  Slot handling
//  - On accept, the slot stores next_addr = base and remaining = num_words.
//  - req_ready falls on the next cycle.
//  - num_words == 0: the slot never touches the engine. req_done pulses 1 cycle after accept.
//  FSM {IDLE, LOAD, RUN, RETIRE}
//  - IDLE: start=0, cfg=0. If any slot is pending, the round-robin winner is chosen,
//    searching from rr_ptr upward with wrap. Then latch grant_id,
//    chunk = min(remaining, MAX_CHUNK), and go to LOAD. A job accepted in a cycle
//    becomes eligible for arbitration the next cycle.
//  - LOAD (1 cycle): cfg_base = next_addr[grant], cfg_num = chunk, start=0, cfg=0.
//    The engine latches base and zeroes its counter. Go to RUN.
//  - RUN: start=1, cfg=1; base and num held stable. dma_batch_done is ignored on the
//    first RUN cycle. When it is seen afterwards, go to RETIRE.
//  - RETIRE (1 cycle): start=0, cfg=0; base and num are still held.
//    - next_addr += chunk, wrapping modulo 2**AW; remaining -= chunk.
//    - rr_ptr = grant_id+1, with wrap.
//    - If remaining reaches 0: the slot frees, req_done[grant] pulses on the next cycle,
//      and req_ready rises on the next cycle.
//    - Go to IDLE.
//  Timing and width rules
//  - Minimum overhead per chunk is 3 cycles (IDLE→LOAD→RUN entry, plus RETIRE)
//    on top of the engine's transfer time.
//  - Arithmetic is unsigned, AW bits wide. No error path: engine backpressure only
//    lengthens RUN.
//  Boundary conditions
//  - req_valid on a busy slot is not accepted; the requester must hold valid.
//  - With only one pending slot, that slot is re-granted back-to-back.
//  - A new job arriving during RUN waits; the current chunk is never preempted.
// STRUCTURE
//  - Package rom_dma_pkg: t_rom_dma_sched_states enum; ROM_ADDR_WIDTH constant;
//    slot record struct {pending, next_addr, remaining}.
//  - Sub-module rr_arbiter (NUM_REQ): inputs req vector and ptr; outputs one-hot grant,
//    grant index, any_grant. Purely combinational.
//  - Top level holds the slot registers, the FSM and the chunk register.
// TESTING
//  1. Single job: slot0 base=0x0100, len=3.
//     -> one LOAD with cfg_num=3 and base=0x0100; RUN until batch_done; req_done[0] pulses once.
//  2. Chunking: MAX_CHUNK=64, slot1 len=150, base=0x0200.
//     -> chunks 64/64/22 at bases 0x0200/0x0240/0x0280; a single req_done[1] after the third chunk.
//  3. Round-robin: slots 0, 2 and 3 post len=128 jobs in the same cycle.
//     -> grant order 0,2,3,0,2,3; each job done after 2 chunks.
//  4. Zero length: slot3 len=0.
//     -> req_done[3] pulses 1 cycle after accept; dma_start_rd never rises.
//  5. Wrap: base=0xFFF0, len=32, MAX_CHUNK=16 -> second chunk base=0x0000.
//  6. Reset in RUN: reset_n low for 1 cycle.
//     -> all outputs 0, req_ready all 1s; a job posted after reset starts at rr slot 0.

Source files
------------

// File: rtl/rom_dma_pkg.sv
// Shared types and constants for the ROM DMA scheduler.
package rom_dma_pkg;

  localparam int unsigned ROM_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RETIRE
  } t_rom_dma_sched_states;

  typedef struct packed {
    logic                      pending;
    logic [ROM_ADDR_WIDTH-1:0] next_addr;
    logic [ROM_ADDR_WIDTH-1:0] remaining;
  } t_slot;

endpackage

// File: rtl/rom_dma_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_grant
);

  int            cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = int'(ptr) + k;
      if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
      cand_idx = IW'(cand);
      if (!any_grant && req[cand_idx]) begin
        any_grant       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rom_dma_scheduler.sv
// Shares one ROM DMA engine between NUM_REQ requesters, round-robin,
// splitting each job into engine batches of at most MAX_CHUNK words.
module rom_dma_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ROM_ADDR_WIDTH = rom_dma_pkg::ROM_ADDR_WIDTH,
  parameter int unsigned MAX_CHUNK      = 64
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*ROM_ADDR_WIDTH-1:0]   req_base_addr,
  input  logic [NUM_REQ*ROM_ADDR_WIDTH-1:0]   req_num_words,
  output logic [NUM_REQ-1:0]                  req_done,
  output logic [ROM_ADDR_WIDTH-1:0]           dma_cfg_base_addr,
  output logic [ROM_ADDR_WIDTH-1:0]           dma_cfg_num_bytes,
  output logic                                dma_start_rd,
  output logic                                dma_cfg_ready,
  input  logic                                dma_batch_done,
  output logic                                sched_busy,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id
);

  import rom_dma_pkg::*;

  localparam int unsigned AW = ROM_ADDR_WIDTH;
  localparam int unsigned IW = $clog2(NUM_REQ);

  t_rom_dma_sched_states state;
  t_slot                 slot_q [NUM_REQ];
  logic [IW-1:0]         rr_ptr;
  logic [AW-1:0]         chunk_q;
  logic                  run_first;

  logic [NUM_REQ-1:0]    pending_vec;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic [AW-1:0]         sel_rem;
  logic [AW-1:0]         sel_addr;
  logic [AW-1:0]         chunk_next;
  logic [AW-1:0]         ret_rem;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req       (pending_vec),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // Winner's slot fields and the size of its next chunk.
  always_comb begin
    pending_vec = '0;
    sel_rem     = '0;
    sel_addr    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      pending_vec[i] = slot_q[i].pending;
      if (arb_grant[i]) begin
        sel_rem  = slot_q[i].remaining;
        sel_addr = slot_q[i].next_addr;
      end
    end
    chunk_next = (sel_rem > AW'(MAX_CHUNK)) ? AW'(MAX_CHUNK) : sel_rem;
    ret_rem    = slot_q[grant_id].remaining - chunk_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      for (int i = 0; i < int'(NUM_REQ); i++) slot_q[i] <= '0;
      rr_ptr            <= '0;
      chunk_q           <= '0;
      run_first         <= 1'b0;
      req_ready         <= '1;
      req_done          <= '0;
      dma_cfg_base_addr <= '0;
      dma_cfg_num_bytes <= '0;
      dma_start_rd      <= 1'b0;
      dma_cfg_ready     <= 1'b0;
      sched_busy        <= 1'b0;
      grant_id          <= '0;
    end else begin
      req_done <= '0;

      // Job intake; zero-length jobs complete immediately without the engine.
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (req_num_words[i*AW +: AW] == '0) begin
            req_done[i] <= 1'b1;
          end else begin
            slot_q[i].pending   <= 1'b1;
            slot_q[i].next_addr <= req_base_addr[i*AW +: AW];
            slot_q[i].remaining <= req_num_words[i*AW +: AW];
            req_ready[i]        <= 1'b0;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (arb_any) begin
            grant_id          <= arb_idx;
            chunk_q           <= chunk_next;
            dma_cfg_base_addr <= sel_addr;
            dma_cfg_num_bytes <= chunk_next;
            sched_busy        <= 1'b1;
            state             <= S_LOAD;
          end
        end
        S_LOAD: begin
          dma_start_rd  <= 1'b1;
          dma_cfg_ready <= 1'b1;
          run_first     <= 1'b1;
          state         <= S_RUN;
        end
        S_RUN: begin
          // A done left over from the previous batch is masked on the first cycle.
          run_first <= 1'b0;
          if (!run_first && dma_batch_done) begin
            dma_start_rd  <= 1'b0;
            dma_cfg_ready <= 1'b0;
            state         <= S_RETIRE;
          end
        end
        S_RETIRE: begin
          slot_q[grant_id].next_addr <= slot_q[grant_id].next_addr + chunk_q;
          slot_q[grant_id].remaining <= ret_rem;
          rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
          if (ret_rem == '0) begin
            slot_q[grant_id].pending <= 1'b0;
            req_done[grant_id]       <= 1'b1;
            req_ready[grant_id]      <= 1'b1;
          end
          sched_busy <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_dma_scheduler.sv
// Self-checking bench for rom_dma_scheduler: job-level reference model, directed table and random traffic.
module tb_rom_dma_scheduler;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int MC = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_base_addr;
  logic [NR*AW-1:0] req_num_words;
  logic [NR-1:0]   req_done;
  logic [AW-1:0]   dma_cfg_base_addr;
  logic [AW-1:0]   dma_cfg_num_bytes;
  logic            dma_start_rd;
  logic            dma_cfg_ready;
  logic            dma_batch_done;
  logic            sched_busy;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  rom_dma_scheduler #(.NUM_REQ(NR), .ROM_ADDR_WIDTH(AW), .MAX_CHUNK(MC)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_base_addr     (req_base_addr),
    .req_num_words     (req_num_words),
    .req_done          (req_done),
    .dma_cfg_base_addr (dma_cfg_base_addr),
    .dma_cfg_num_bytes (dma_cfg_num_bytes),
    .dma_start_rd      (dma_start_rd),
    .dma_cfg_ready     (dma_cfg_ready),
    .dma_batch_done    (dma_batch_done),
    .sched_busy        (sched_busy),
    .grant_id          (grant_id)
  );

  // Engine stand-in: counts words while started, optionally with random stalls.
  logic [AW-1:0] eng_cnt;
  logic          stall_en, force_done_en, force_done_val;
  always @(posedge clk) begin
    if (!dma_start_rd) eng_cnt <= '0;
    else if (!(stall_en && $urandom_range(0, 1) == 1)) eng_cnt <= eng_cnt + 16'd1;
  end
  assign dma_batch_done = force_done_en ? force_done_val
                                        : (dma_start_rd && eng_cnt >= dma_cfg_num_bytes);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: slot bookkeeping plus the chunk in flight.
  int          m_phase;   // 0 idle, 1 program, 2 engine running, 3 retire
  int          m_grant, m_rr;
  bit          m_first;
  logic [3:0]  m_pend, m_done_exp;
  logic [15:0] m_addr [NR];
  logic [15:0] m_rem  [NR];
  logic [15:0] m_chunk;

  function automatic int rr_pick(input logic [3:0] p, input int ptr);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr + k) % NR;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [3:0] old_pend;
    int w;
    old_pend = m_pend;
    if (!reset_n) begin
      m_phase = 0; m_grant = 0; m_rr = 0; m_first = 0;
      m_pend = '0; m_done_exp = '0; m_chunk = '0;
      for (int i = 0; i < NR; i++) begin m_addr[i] = '0; m_rem[i] = '0; end
      return;
    end
    m_done_exp = '0;
    case (m_phase)
      0: begin
        w = rr_pick(m_pend, m_rr);
        if (w >= 0) begin
          m_grant = w;
          m_chunk = (m_rem[w] > 16'(MC)) ? 16'(MC) : m_rem[w];
          m_phase = 1;
        end
      end
      1: begin m_phase = 2; m_first = 1; end
      2: begin
        if (!m_first && dma_batch_done) m_phase = 3;
        m_first = 0;
      end
      default: begin
        m_addr[m_grant] = m_addr[m_grant] + m_chunk;
        m_rem[m_grant]  = m_rem[m_grant] - m_chunk;
        m_rr = (m_grant + 1) % NR;
        if (m_rem[m_grant] == 0) begin
          m_pend[m_grant]     = 1'b0;
          m_done_exp[m_grant] = 1'b1;
        end
        m_phase = 0;
      end
    endcase
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && !old_pend[i]) begin
        if (req_num_words[i*AW +: AW] == 0) m_done_exp[i] = 1'b1;
        else begin
          m_pend[i] = 1'b1;
          m_addr[i] = req_base_addr[i*AW +: AW];
          m_rem[i]  = req_num_words[i*AW +: AW];
        end
      end
    end
  endtask

  typedef struct {
    int          id;
    logic [15:0] base;
    logic [15:0] num;
  } chunk_t;

  chunk_t log_q[$];
  int     done_cnt [NR];
  int     start_cycles;
  bit     check_en = 0;

  always @(negedge clk) begin
    logic [3:0] rdy_exp;
    if (check_en) begin
      rdy_exp = ~m_pend;
      chk("busy",  32'(sched_busy),    32'(m_phase != 0));
      chk("start", 32'(dma_start_rd),  32'(m_phase == 2));
      chk("cfg",   32'(dma_cfg_ready), 32'(m_phase == 2));
      chk("ready", 32'(req_ready),     32'(rdy_exp));
      chk("done",  32'(req_done),      32'(m_done_exp));
      if (m_phase != 0) begin
        chk("grant_id", 32'(grant_id),          32'(m_grant));
        chk("cfg_base", 32'(dma_cfg_base_addr), 32'(m_addr[m_grant]));
        chk("cfg_num",  32'(dma_cfg_num_bytes), 32'(m_chunk));
      end
      if (m_phase == 1) log_q.push_back('{int'(grant_id), dma_cfg_base_addr, dma_cfg_num_bytes});
      for (int i = 0; i < NR; i++) done_cnt[i] += int'(req_done[i]);
      if (dma_start_rd) start_cycles++;
    end
    model_step();
  end

  logic [15:0] jb_base [NR];
  logic [15:0] jb_len  [NR];

  task automatic clear_log();
    log_q.delete();
    for (int i = 0; i < NR; i++) done_cnt[i] = 0;
    start_cycles = 0;
  endtask

  // Offer jobs on every slot in mask, holding valid until each is accepted.
  task automatic post_jobs(input logic [3:0] mask);
    logic [3:0] acc;
    int guard;
    guard = 0;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      if (mask[i]) begin
        req_base_addr[i*AW +: AW] = jb_base[i];
        req_num_words[i*AW +: AW] = jb_len[i];
      end
    end
    req_valid = mask;
    while (req_valid != 0 && guard < 2000) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
      guard++;
    end
    chk("post_accept", 32'(req_valid), 32'd0);
    req_valid = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_ready == 4'hF && !sched_busy && req_done == 4'h0) && n < budget);
    chk("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  typedef struct {
    int          slot;
    logic [15:0] base;
    logic [15:0] len;
    int          chunks;
    logic [15:0] fb, fn, lb, ln;
  } vec_t;

  vec_t vecs [4];
  int   rr_ids [6];
  logic [15:0] rr_bases [6];

  initial begin
    logic [3:0] acc;
    int bad, guard;

    vecs[0] = '{0, 16'h0100, 16'd3,   1, 16'h0100, 16'd3,  16'h0100, 16'd3};
    vecs[1] = '{1, 16'h0200, 16'd150, 3, 16'h0200, 16'd64, 16'h0280, 16'd22};
    vecs[2] = '{3, 16'h1234, 16'd0,   0, 16'h0000, 16'd0,  16'h0000, 16'd0};
    vecs[3] = '{2, 16'hFFF0, 16'd100, 2, 16'hFFF0, 16'd64, 16'h0030, 16'd36};
    rr_ids   = '{0, 2, 3, 0, 2, 3};
    rr_bases = '{16'h1000, 16'h2000, 16'h3000, 16'h1040, 16'h2040, 16'h3040};

    reset_n = 1'b0;
    req_valid = '0;
    req_base_addr = '0;
    req_num_words = '0;
    stall_en = 1'b0;
    force_done_en = 1'b0;
    force_done_val = 1'b0;
    clear_log();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_en = 1;

    @(negedge clk);
    chk("rst_base",  32'(dma_cfg_base_addr), 32'd0);
    chk("rst_num",   32'(dma_cfg_num_bytes), 32'd0);
    chk("rst_grant", 32'(grant_id),          32'd0);
    chk("rst_ready", 32'(req_ready),         32'hF);

    // Single jobs: length, chunking, zero length, address wrap.
    for (int r = 0; r < 4; r++) begin
      clear_log();
      jb_base[vecs[r].slot] = vecs[r].base;
      jb_len[vecs[r].slot]  = vecs[r].len;
      post_jobs(4'(1 << vecs[r].slot));
      wait_idle(5000);
      chk("row_chunks", 32'(log_q.size()), 32'(vecs[r].chunks));
      chk("row_done",   32'(done_cnt[vecs[r].slot]), 32'd1);
      if (log_q.size() > 0) begin
        chk("row_first_base", 32'(log_q[0].base), 32'(vecs[r].fb));
        chk("row_first_num",  32'(log_q[0].num),  32'(vecs[r].fn));
        chk("row_last_base",  32'(log_q[log_q.size()-1].base), 32'(vecs[r].lb));
        chk("row_last_num",   32'(log_q[log_q.size()-1].num),  32'(vecs[r].ln));
      end else begin
        chk("row_no_start", 32'(start_cycles), 32'd0);
      end
      bad = 0;
      foreach (log_q[k]) if (log_q[k].id != vecs[r].slot) bad++;
      chk("row_ids", 32'(bad), 32'd0);
    end

    // Round-robin across three simultaneous jobs.
    do_reset();
    clear_log();
    jb_base[0] = 16'h1000; jb_len[0] = 16'd128;
    jb_base[2] = 16'h2000; jb_len[2] = 16'd128;
    jb_base[3] = 16'h3000; jb_len[3] = 16'd128;
    post_jobs(4'b1101);
    wait_idle(5000);
    chk("rr_count", 32'(log_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < log_q.size()) begin
        chk("rr_id",   32'(log_q[k].id),   32'(rr_ids[k]));
        chk("rr_base", 32'(log_q[k].base), 32'(rr_bases[k]));
      end
    end
    chk("rr_done0", 32'(done_cnt[0]), 32'd1);
    chk("rr_done2", 32'(done_cnt[2]), 32'd1);
    chk("rr_done3", 32'(done_cnt[3]), 32'd1);

    // Reset while the engine runs the second chunk of a job.
    clear_log();
    jb_base[1] = 16'h4000; jb_len[1] = 16'd200;
    post_jobs(4'b0010);
    guard = 0;
    while (!(log_q.size() == 2 && dma_start_rd) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("run_reach", 32'(guard < 2000), 32'd1);
    do_reset();
    @(negedge clk);
    chk("rr_rst_busy",  32'(sched_busy),        32'd0);
    chk("rr_rst_start", 32'(dma_start_rd),      32'd0);
    chk("rr_rst_cfg",   32'(dma_cfg_ready),     32'd0);
    chk("rr_rst_base",  32'(dma_cfg_base_addr), 32'd0);
    chk("rr_rst_num",   32'(dma_cfg_num_bytes), 32'd0);
    chk("rr_rst_grant", 32'(grant_id),          32'd0);
    chk("rr_rst_ready", 32'(req_ready),         32'hF);
    chk("rr_rst_nodone", 32'(done_cnt[1]),      32'd0);
    clear_log();
    jb_base[0] = 16'h5000; jb_len[0] = 16'd5;
    jb_base[3] = 16'h6000; jb_len[3] = 16'd5;
    post_jobs(4'b1001);
    wait_idle(2000);
    chk("post_rst_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("post_rst_first",  32'(log_q[0].id), 32'd0);
      chk("post_rst_second", 32'(log_q[1].id), 32'd3);
    end

    // A done already high on RUN entry must be ignored for one cycle.
    force_done_en = 1'b1;
    force_done_val = 1'b1;
    clear_log();
    jb_base[2] = 16'h0500; jb_len[2] = 16'd10;
    post_jobs(4'b0100);
    wait_idle(200);
    chk("stale_done_run", 32'(start_cycles), 32'd2);
    force_done_en = 1'b0;

    // Random traffic with engine stalls.
    stall_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_base_addr[i*AW +: AW] = 16'($urandom);
          req_num_words[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 150));
          req_valid[i] = 1'b1;
        end
      end
    end
    guard = 0;
    while (req_valid != 0 && guard < 20000) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
      guard++;
    end
    chk("rand_drain", 32'(req_valid), 32'd0);
    req_valid = '0;
    wait_idle(20000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
